// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router ingress path.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int REM_W     = LEN_W + 1;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DROP
  } state_t;

  // One-hot write enable for a port; the invalid address maps to no port.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addr == p[ADDR_W-1:0]) v[p] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; compares against the parity byte
// and produces a registered one-cycle mismatch pulse.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_acc,
  input  logic              i_cmp,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_err
);

  logic [DATA_W-1:0] r_acc;
  logic              r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= i_cmp && (i_byte != r_acc);
      if (i_load) begin
        r_acc <= i_byte;
      end else if (i_acc) begin
        r_acc <= r_acc ^ i_byte;
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/router_ingress_ctrl.sv
// Ingress controller: decodes the header, steers bytes into one of three
// output FIFOs, throttles the source and flags parity errors and drops.
module router_ingress_ctrl
  import router_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_din_valid,
  input  logic [DATA_W-1:0]    i_din,
  input  logic [NUM_PORTS-1:0] i_fifo_full,
  input  logic [NUM_PORTS-1:0] i_fifo_empty,
  input  logic [NUM_PORTS-1:0] i_fifo_soft_rst,
  output logic [NUM_PORTS-1:0] o_we,
  output logic                 o_lfd_state,
  output logic [DATA_W-1:0]    o_dout,
  output logic                 o_busy,
  output logic                 o_err,
  output logic                 o_drop
);

  state_t            r_state;
  logic [DATA_W-1:0] r_hdr;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [REM_W-1:0]  r_rem;
  logic              r_drop;

  logic              w_full;
  logic              w_empty;
  logic              w_soft;
  logic              w_hdr_empty;
  logic              w_busy;
  logic              w_write;
  logic              w_lfd;
  logic              w_accept;
  logic [DATA_W-1:0] w_dout;
  logic [LEN_W-1:0]  w_cnt_next;
  logic [REM_W-1:0]  w_rem_abort;
  logic [ADDR_W-1:0] w_din_addr;
  logic [LEN_W-1:0]  w_din_len;

  assign w_din_addr = i_din[ADDR_MSB:ADDR_LSB];
  assign w_din_len  = i_din[LEN_MSB:LEN_LSB];

  // Per-port status muxed by the latched address (and by the incoming header in IDLE).
  always_comb begin
    w_full      = 1'b0;
    w_empty     = 1'b0;
    w_soft      = 1'b0;
    w_hdr_empty = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_addr == p[ADDR_W-1:0]) begin
        w_full  = i_fifo_full[p];
        w_empty = i_fifo_empty[p];
        w_soft  = i_fifo_soft_rst[p];
      end
      if (w_din_addr == p[ADDR_W-1:0]) begin
        w_hdr_empty = i_fifo_empty[p];
      end
    end
  end

  // A soft reset holds the source off so the aborted cycle never swallows a byte.
  always_comb begin
    w_busy = 1'b0;
    w_write = 1'b0;
    w_lfd = 1'b0;
    w_dout = '0;
    w_rem_abort = {1'b0, r_len} + 7'd1;
    case (r_state)
      S_WAIT_EMPTY: begin
        w_busy = 1'b1;
      end
      S_HEADER: begin
        w_busy  = 1'b1;
        w_write = !w_soft && !w_full;
        w_lfd   = w_write;
        w_dout  = r_hdr;
      end
      S_PAYLOAD: begin
        w_busy      = w_full || w_soft;
        w_write     = i_din_valid && !w_busy;
        w_dout      = i_din;
        w_rem_abort = {1'b0, (r_len - r_cnt)} + 7'd1;
      end
      S_PARITY: begin
        w_busy      = w_full || w_soft;
        w_write     = i_din_valid && !w_busy;
        w_dout      = i_din;
        w_rem_abort = 7'd1;
      end
      default: begin
      end
    endcase
  end

  assign w_accept   = i_din_valid && !w_busy;
  assign w_cnt_next = r_cnt + 6'd1;

  assign o_we        = w_write ? port_onehot(r_addr) : '0;
  assign o_lfd_state = w_lfd;
  assign o_dout      = w_dout;
  assign o_busy      = w_busy;
  assign o_drop      = r_drop;

  // Packet sequencing, byte counting and drop bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_hdr   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hdr  <= i_din;
            r_addr <= w_din_addr;
            r_len  <= w_din_len;
            r_cnt  <= '0;
            if (w_din_addr == ADDR_INVALID) begin
              r_state <= S_DROP;
              r_rem   <= {1'b0, w_din_len} + 7'd1;
              r_drop  <= 1'b1;
            end else if (!w_hdr_empty) begin
              r_state <= S_WAIT_EMPTY;
            end else begin
              r_state <= S_HEADER;
            end
          end
        end
        S_WAIT_EMPTY: begin
          if (w_soft) begin
            r_state <= S_DROP;
            r_rem   <= w_rem_abort;
            r_drop  <= 1'b1;
          end else if (w_empty) begin
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_soft) begin
            r_state <= S_DROP;
            r_rem   <= w_rem_abort;
            r_drop  <= 1'b1;
          end else if (w_write) begin
            r_state <= (r_len == '0) ? S_PARITY : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_soft) begin
            r_state <= S_DROP;
            r_rem   <= w_rem_abort;
            r_drop  <= 1'b1;
          end else if (w_write) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_len) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_soft) begin
            r_state <= S_DROP;
            r_rem   <= w_rem_abort;
            r_drop  <= 1'b1;
          end else if (w_write) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (w_accept) begin
            r_rem <= r_rem - 7'd1;
            if (r_rem == 7'd1) r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  router_parity_acc u_parity (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (r_state == S_IDLE && w_accept),
    .i_acc  (r_state == S_PAYLOAD && w_write),
    .i_cmp  (r_state == S_PARITY && w_write),
    .i_byte (i_din),
    .o_err  (o_err)
  );

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed bench for router_ingress_ctrl; expected FIFO writes are queued by the
// stimulus and popped by an independent monitor whenever a write appears.
module tb_router_ingress_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dinValid;
  logic [7:0] din;
  logic [2:0] fifoFull;
  logic [2:0] fifoEmpty;
  logic [2:0] fifoSoftRst;
  logic [2:0] we;
  logic       lfdState;
  logic [7:0] dout;
  logic       busy;
  logic       err;
  logic       drop;

  typedef struct {
    logic [2:0] we;
    logic       lfd;
    logic [7:0] data;
    logic       isPar;
    logic       expErr;
  } sbItem_t;

  sbItem_t sbQueue[$];

  int   checks     = 0;
  int   errors     = 0;
  int   writeCount = 0;
  int   dropSeen   = 0;
  int   expDrops   = 0;
  logic errPending = 1'b0;
  logic errExp     = 1'b0;

  always #5 clk = ~clk;

  router_ingress_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_din_valid     (dinValid),
    .i_din           (din),
    .i_fifo_full     (fifoFull),
    .i_fifo_empty    (fifoEmpty),
    .i_fifo_soft_rst (fifoSoftRst),
    .o_we            (we),
    .o_lfd_state     (lfdState),
    .o_dout          (dout),
    .o_busy          (busy),
    .o_err           (err),
    .o_drop          (drop)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it; returns stall cycles.
  task automatic applyStimulus(input logic [7:0] b, output int waits);
    bit accepted;
    accepted = 0;
    waits    = 0;
    dinValid = 1'b1;
    din      = b;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (!busy) accepted = 1;
      else waits++;
      @(posedge clk);
      #1;
    end
    dinValid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: byte %0h not accepted, required acceptance within 200 cycles", b);
    end
  endtask

  task automatic sendPacket(input logic [7:0] hdr, input logic [7:0] parXor,
                            input int softAfter, input int fullAt, input int emptyDelay);
    logic [1:0] addr;
    int         len;
    int         nPay;
    int         w;
    int         startWrites;
    logic [7:0] pay[64];
    logic [7:0] par;
    logic [2:0] weExp;
    sbItem_t    it;

    addr = hdr[1:0];
    len  = int'(hdr[7:2]);
    par  = hdr;
    for (int i = 0; i < len; i++) begin
      pay[i] = 8'(i * 29 + 7) ^ hdr;
      par    = par ^ pay[i];
    end
    par         = par ^ parXor;
    startWrites = writeCount;

    if (addr == 2'd3) begin
      expDrops++;
      applyStimulus(hdr, w);
      for (int i = 0; i <= len; i++) begin
        applyStimulus((i < len) ? pay[i] : par, w);
        checkOutput("dropBusy", w, 0);
      end
      checkOutput("dropWrites", writeCount - startWrites, 0);
      return;
    end

    weExp = 3'b001 << addr;
    it = '{we: weExp, lfd: 1'b1, data: hdr, isPar: 1'b0, expErr: 1'b0};
    sbQueue.push_back(it);
    nPay = (softAfter >= 0) ? softAfter : len;
    for (int i = 0; i < nPay; i++) begin
      it = '{we: weExp, lfd: 1'b0, data: pay[i], isPar: 1'b0, expErr: 1'b0};
      sbQueue.push_back(it);
    end
    if (softAfter < 0) begin
      it = '{we: weExp, lfd: 1'b0, data: par, isPar: 1'b1, expErr: (parXor != 8'h00)};
      sbQueue.push_back(it);
    end

    if (emptyDelay > 0) fifoEmpty[addr] = 1'b0;
    applyStimulus(hdr, w);
    if (emptyDelay > 0) begin
      for (int i = 0; i < emptyDelay; i++) begin
        @(negedge clk);
        checkOutput("waitBusy", busy, 1);
        checkOutput("waitNoWe", we, 0);
        @(posedge clk);
        #1;
      end
      fifoEmpty[addr] = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("hdrWe", we, weExp);
    checkOutput("hdrLfd", lfdState, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < len; i++) begin
      if (i == softAfter) begin
        expDrops++;
        fifoSoftRst[addr] = 1'b1;
        @(negedge clk);
        checkOutput("softNoWe", we, 0);
        @(posedge clk);
        #1;
        fifoSoftRst[addr] = 1'b0;
        for (int j = i; j <= len; j++) begin
          applyStimulus((j < len) ? pay[j] : par, w);
          checkOutput("absorbBusy", w, 0);
        end
        checkOutput("softWrites", writeCount - startWrites, 1 + softAfter);
        return;
      end
      if (i == fullAt) begin
        fifoFull[addr] = 1'b1;
        dinValid       = 1'b1;
        din            = pay[i];
        repeat (3) begin
          @(negedge clk);
          checkOutput("fullBusy", busy, 1);
          checkOutput("fullNoWe", we, 0);
          @(posedge clk);
          #1;
        end
        fifoFull[addr] = 1'b0;
      end
      applyStimulus(pay[i], w);
    end
    applyStimulus(par, w);
    checkOutput("pktWrites", writeCount - startWrites, len + 2);
  endtask

  // Monitor: pops the scoreboard on every write and checks err the cycle after parity.
  initial begin
    sbItem_t item;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (errPending) begin
          checkOutput("errPulse", err, errExp);
          errPending = 1'b0;
        end else if (err) begin
          checkOutput("strayErr", err, 0);
        end
        if (drop) dropSeen++;
        if (we != 3'b000) begin
          writeCount++;
          if (sbQueue.size() == 0) begin
            checkOutput("unexpectedWe", we, 0);
          end else begin
            item = sbQueue.pop_front();
            checkOutput("wrWe", we, item.we);
            checkOutput("wrLfd", lfdState, item.lfd);
            checkOutput("wrData", dout, item.data);
            if (item.isPar) begin
              errPending = 1'b1;
              errExp     = item.expErr;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    dinValid    = 1'b0;
    din         = 8'h00;
    fifoFull    = 3'b000;
    fifoEmpty   = 3'b111;
    fifoSoftRst = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstWe", we, 0);
    checkOutput("rstLfd", lfdState, 0);
    checkOutput("rstDout", dout, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstDrop", drop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] good parity packet 8'h3A");
    sendPacket(8'h3A, 8'h00, -1, -1, 0);
    $display("[TB] bad parity packet 8'h3A");
    sendPacket(8'h3A, 8'h01, -1, -1, 0);
    $display("[TB] invalid address 8'h0F then 8'h01");
    sendPacket(8'h0F, 8'h00, -1, -1, 0);
    sendPacket(8'h01, 8'h00, -1, -1, 0);
    $display("[TB] full stall on port 0");
    sendPacket(8'h10, 8'h00, -1, 2, 0);
    $display("[TB] wait for empty on port 1");
    sendPacket(8'h05, 8'h00, -1, -1, 5);
    $display("[TB] soft reset mid-payload then len-0 packet");
    sendPacket(8'h3A, 8'h00, 4, -1, 0);
    sendPacket(8'h02, 8'h00, -1, -1, 0);
    $display("[TB] maximum length packet");
    sendPacket(8'hFC, 8'h00, -1, -1, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sbDrained", sbQueue.size(), 0);
    checkOutput("dropCount", dropSeen, expDrops);
    checkOutput("errSettled", errPending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_ingress_ctrl.md
# router_ingress_ctrl

Packet ingress controller for the 1x3 router: accepts the byte stream from the source, decodes the destination from the header, and drives the write side of the three output `fifo_router` instances. It sits directly upstream of those FIFOs. It produces `we`, `lfd_state` and `din` for each FIFO, throttles the source with `busy`, and checks packet parity.

## Interface
- `NUM_PORTS`, 3: number of output FIFOs; addresses 0..2 valid, 3 invalid.
- `DATA_W`, 8: byte width; header layout fixed at {len[5:0], addr[1:0]}.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din_valid` in 1: source byte valid; a byte is accepted when `din_valid && !busy`.
- `din` in 8: source byte.
- `fifo_full` in 3: per-FIFO `full`.
- `fifo_empty` in 3: per-FIFO `empty`.
- `fifo_soft_rst` in 3: per-FIFO soft reset (timeout flush downstream).
- `we` out 3: one-hot FIFO write enable (to `we`).
- `lfd_state` out 1: high only on the header write (to `lfd_state`).
- `dout` out 8: byte to FIFO `din`.
- `busy` out 1: source must hold `din`/`din_valid`.
- `err` out 1: parity-mismatch pulse.
- `drop` out 1: packet-discarded pulse.

## Operation
- Packet: header, `len` payload bytes (0..63), then 1 parity byte. Parity is the XOR of the header and all payload bytes.
- States: IDLE, WAIT_EMPTY, HEADER, PAYLOAD, PARITY, DROP.
- IDLE: `busy`=0. On accept, latch the header into `hdr_reg`, latch `addr` and `len`, and set `par_acc`=header.
  - addr==3: go to DROP with rem=len+1.
  - `fifo_empty[addr]`=0: go to WAIT_EMPTY.
  - Otherwise: go to HEADER.
- WAIT_EMPTY: `busy`=1. Go to HEADER once `fifo_empty[addr]`=1.
- HEADER: `busy`=1 for exactly one cycle.
  - Drives `we[addr]`=1, `lfd_state`=1, `dout`=`hdr_reg`.
  - Next state is PAYLOAD, or PARITY if len==0.
- PAYLOAD: `busy`=`fifo_full[addr]`. Each accepted byte is passed through combinationally.
  - `we[addr]`=1, `dout`=`din`, `par_acc`^=`din`, cnt++.
  - When cnt reaches len, go to PARITY.
- PARITY: `busy`=`fifo_full[addr]`. The accepted byte is written to the FIFO like a payload byte.
  - Next cycle `err`=1 if `din`≠`par_acc`.
  - Go to IDLE; a new header can be accepted the cycle after.
- DROP: `busy`=0. Accepted bytes are discarded with no `we`; rem decrements per byte. Go to IDLE when rem reaches 0.
  - `drop` pulses 1 cycle on the cycle after entering DROP.
- Soft reset: `fifo_soft_rst[addr]`=1 in WAIT_EMPTY, HEADER, PAYLOAD or PARITY aborts the packet. No write occurs that cycle. Go to DROP with rem = remaining bytes including parity.
- `we` is only ever asserted for the latched `addr`; writes are never issued while `fifo_full[addr]`=1.
- cnt is 6 bits; len=63 produces no wrap.
- Reset mid-packet: return to IDLE immediately and discard the rest of the packet.

## Timing
- Reset values: state=IDLE, `we`=0, `lfd_state`=0, `dout`=0, `busy`=0, `err`=0, `drop`=0, cnt=0, rem=0, `par_acc`=0.
- `we`, `lfd_state`, `dout` and `busy` decode combinationally from state and inputs. `err` and `drop` are registered 1-cycle pulses.
- Header latency: header accepted at edge N gives the header write in cycle N+1 when the FIFO is empty.
- Payload and parity latency is zero (same-cycle pass-through).
- Minimum packet occupancy is len+3 cycles (header accept, HEADER cycle, len payload, parity).
- `busy` falling: the source may present the next byte in that same cycle.

## Structure
- `router_pkg`: state enum; `ADDR_INVALID`=2'd3; header field slices (`LEN_MSB`/`LEN_LSB`, `ADDR_MSB`/`ADDR_LSB`); `NUM_PORTS`.
- One sub-module, `router_parity_acc`: load/accumulate/compare, producing the `err` pulse.
- The FSM, counters and the one-hot `we` decode live in `router_ingress_ctrl`.

## Test plan
- Header 8'h3A (len 14, addr 2), FIFO2 empty, correct parity: `we`=3'b100 with `lfd_state`=1 and `dout`=8'h3A in cycle N+1. Then 15 pass-through writes follow; `err`=0; 16 total writes.
- Same packet with parity XOR 8'h01: all 16 bytes written; `err`=1 for exactly one cycle after the parity accept.
- Header 8'h0F (addr 3, len 3): `drop` pulses; 4 following bytes absorbed with `busy`=0 and `we`=0; next header 8'h01 is handled normally.
- Addr 0 packet, `fifo_full[0]` forced high for 3 cycles mid-payload: `busy`=1 and `we`=0 for those cycles. No byte is lost or duplicated; FIFO contents match the stimulus.
- Header 8'h05 (len 1, addr 1) with `fifo_empty[1]`=0 for 5 cycles: `busy`=1 and no write. Header is written the cycle after empty rises.
- `fifo_soft_rst[2]` pulsed after the 4th payload byte of the 8'h3A packet: `drop` pulses, 11 remaining bytes absorbed, no further `we`. A following len-0 packet (8'h02, parity 8'h02) gives 2 writes and `err`=0.
